// File: rtl/axi_mem_if_pkg.sv
// Shared definitions for the AXI-to-SRAM bridge controllers: response codes,
// burst encodings and the write-controller state type.
package axi_mem_if_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] BURST_WRAP  = 2'b10;
  localparam logic [1:0] BURST_RSVD  = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WRITE = 2'd1,
    ST_RESP  = 2'd2
  } wr_state_t;

endpackage

// File: rtl/axi_write_only_ctrl.sv
// AXI4 write-channel controller: one memory write per accepted W beat through the
// arbitrated memory port, one B response per burst.
module axi_write_only_ctrl
  import axi_mem_if_pkg::*;
#(
  parameter int AXI4_ADDRESS_WIDTH = 32,
  parameter int AXI4_WDATA_WIDTH   = 64,
  parameter int AXI4_ID_WIDTH      = 16,
  parameter int AXI4_USER_WIDTH    = 10,
  parameter int AXI_NUMBYTES       = AXI4_WDATA_WIDTH / 8,
  parameter int MEM_ADDR_WIDTH     = 13
) (
  input  logic                          clk,
  input  logic                          rst,

  input  logic [AXI4_ID_WIDTH-1:0]      AWID_i,
  input  logic [AXI4_ADDRESS_WIDTH-1:0] AWADDR_i,
  input  logic [7:0]                    AWLEN_i,
  input  logic [2:0]                    AWSIZE_i,
  input  logic [1:0]                    AWBURST_i,
  input  logic                          AWLOCK_i,
  input  logic [3:0]                    AWCACHE_i,
  input  logic [2:0]                    AWPROT_i,
  input  logic [3:0]                    AWREGION_i,
  input  logic [AXI4_USER_WIDTH-1:0]    AWUSER_i,
  input  logic [3:0]                    AWQOS_i,
  input  logic                          AWVALID_i,
  output logic                          AWREADY_o,

  input  logic [AXI4_WDATA_WIDTH-1:0]   WDATA_i,
  input  logic [AXI_NUMBYTES-1:0]       WSTRB_i,
  input  logic                          WLAST_i,
  input  logic [AXI4_USER_WIDTH-1:0]    WUSER_i,
  input  logic                          WVALID_i,
  output logic                          WREADY_o,

  output logic [AXI4_ID_WIDTH-1:0]      BID_o,
  output logic [1:0]                    BRESP_o,
  output logic [AXI4_USER_WIDTH-1:0]    BUSER_o,
  output logic                          BVALID_o,
  input  logic                          BREADY_i,

  output logic                          MEM_CEN_o,
  output logic                          MEM_WEN_o,
  output logic [MEM_ADDR_WIDTH-1:0]     MEM_A_o,
  output logic [AXI4_WDATA_WIDTH-1:0]   MEM_D_o,
  output logic [AXI_NUMBYTES-1:0]       MEM_BE_o,
  input  logic [AXI4_WDATA_WIDTH-1:0]   MEM_Q_i,

  output logic                          valid_o,
  input  logic                          grant_i
);

  localparam int OFFSET_BIT = $clog2(AXI4_WDATA_WIDTH) - 3;

  wr_state_t                   state_reg, state_next;
  logic [AXI4_ID_WIDTH-1:0]    bid_reg, bid_next;
  logic [AXI4_USER_WIDTH-1:0]  buser_reg, buser_next;
  logic [MEM_ADDR_WIDTH-1:0]   base_reg, base_next;
  logic [7:0]                  len_reg, len_next;
  logic [1:0]                  burst_reg, burst_next;
  logic [7:0]                  count_reg, count_next;
  logic                        error_reg, error_next;

  logic                        load_aw;
  logic                        last_beat;
  logic                        beat_accept;
  logic [MEM_ADDR_WIDTH-1:0]   addr_offset;

  // Only the word-address slice of AWADDR and the listed AW/W fields matter;
  // the rest are tied into a sink so the ignored ports stay visibly intentional.
  logic unused_inputs;
  assign unused_inputs = ^{AWADDR_i, AWSIZE_i, AWLOCK_i, AWCACHE_i, AWPROT_i,
                           AWREGION_i, AWQOS_i, WUSER_i, MEM_Q_i};

  assign last_beat   = (count_reg == len_reg);
  assign beat_accept = WVALID_i & grant_i;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= ST_IDLE;
      bid_reg   <= '0;
      buser_reg <= '0;
      base_reg  <= '0;
      len_reg   <= '0;
      burst_reg <= BURST_INCR;
      count_reg <= '0;
      error_reg <= 1'b0;
    end else begin
      state_reg <= state_next;
      bid_reg   <= bid_next;
      buser_reg <= buser_next;
      base_reg  <= base_next;
      len_reg   <= len_next;
      burst_reg <= burst_next;
      count_reg <= count_next;
      error_reg <= error_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    load_aw    = 1'b0;
    AWREADY_o  = 1'b0;
    WREADY_o   = 1'b0;
    valid_o    = 1'b0;
    MEM_CEN_o  = 1'b1;
    MEM_WEN_o  = 1'b1;
    BVALID_o   = 1'b0;
    count_next = count_reg;
    error_next = error_reg;

    case (state_reg)
      ST_IDLE: begin
        AWREADY_o = 1'b1;
        if (AWVALID_i) begin
          load_aw    = 1'b1;
          state_next = ST_WRITE;
        end
      end

      ST_WRITE: begin
        valid_o   = WVALID_i;
        MEM_CEN_o = ~WVALID_i;
        MEM_WEN_o = ~WVALID_i;
        WREADY_o  = grant_i;
        if (beat_accept) begin
          // A misplaced WLAST is flagged but never shortens or extends the burst.
          if (WLAST_i != last_beat)
            error_next = 1'b1;
          if (last_beat)
            state_next = ST_RESP;
          else
            count_next = count_reg + 8'd1;
        end
      end

      ST_RESP: begin
        BVALID_o = 1'b1;
        if (BREADY_i) begin
          AWREADY_o = 1'b1;
          if (AWVALID_i) begin
            load_aw    = 1'b1;
            state_next = ST_WRITE;
          end else begin
            state_next = ST_IDLE;
          end
        end
      end

      default: state_next = ST_IDLE;
    endcase

    if (load_aw) begin
      count_next = '0;
      error_next = (AWBURST_i == BURST_RSVD);
    end
  end

  always_comb begin
    bid_next   = bid_reg;
    buser_next = buser_reg;
    base_next  = base_reg;
    len_next   = len_reg;
    burst_next = burst_reg;
    if (load_aw) begin
      bid_next   = AWID_i;
      buser_next = AWUSER_i;
      base_next  = AWADDR_i[MEM_ADDR_WIDTH+OFFSET_BIT-1:OFFSET_BIT];
      len_next   = AWLEN_i;
      burst_next = AWBURST_i;
    end
  end

  // WRAP walks linearly like INCR; the sum wraps naturally at the memory size.
  always_comb begin
    addr_offset = '0;
    case (burst_reg)
      BURST_FIXED: addr_offset = '0;
      BURST_INCR,
      BURST_WRAP:  addr_offset = MEM_ADDR_WIDTH'(count_reg);
      default:     addr_offset = MEM_ADDR_WIDTH'(count_reg);
    endcase
  end

  assign MEM_A_o  = base_reg + addr_offset;
  assign MEM_D_o  = WDATA_i;
  assign MEM_BE_o = WSTRB_i;

  assign BID_o    = bid_reg;
  assign BUSER_o  = buser_reg;
  assign BRESP_o  = error_reg ? RESP_SLVERR : RESP_OKAY;

endmodule

// File: tb/tb_axi_write_only_ctrl.sv
// Directed bench for axi_write_only_ctrl: single writes, bursts, error responses,
// response backpressure with back-to-back AW, address wrap and reset mid-burst.
module tb_axi_write_only_ctrl;
  import axi_mem_if_pkg::*;

  logic        clk;
  logic        rst;
  logic [15:0] AWID;
  logic [31:0] AWADDR;
  logic [7:0]  AWLEN;
  logic [2:0]  AWSIZE;
  logic [1:0]  AWBURST;
  logic        AWLOCK;
  logic [3:0]  AWCACHE;
  logic [2:0]  AWPROT;
  logic [3:0]  AWREGION;
  logic [9:0]  AWUSER;
  logic [3:0]  AWQOS;
  logic        AWVALID;
  logic        AWREADY;
  logic [63:0] WDATA;
  logic [7:0]  WSTRB;
  logic        WLAST;
  logic [9:0]  WUSER;
  logic        WVALID;
  logic        WREADY;
  logic [15:0] BID;
  logic [1:0]  BRESP;
  logic [9:0]  BUSER;
  logic        BVALID;
  logic        BREADY;
  logic        MEM_CEN;
  logic        MEM_WEN;
  logic [12:0] MEM_A;
  logic [63:0] MEM_D;
  logic [7:0]  MEM_BE;
  logic [63:0] MEM_Q;
  logic        valid;
  logic        grant;

  int checks = 0;
  int errors = 0;

  axi_write_only_ctrl dut (
    .clk(clk), .rst(rst),
    .AWID_i(AWID), .AWADDR_i(AWADDR), .AWLEN_i(AWLEN), .AWSIZE_i(AWSIZE),
    .AWBURST_i(AWBURST), .AWLOCK_i(AWLOCK), .AWCACHE_i(AWCACHE), .AWPROT_i(AWPROT),
    .AWREGION_i(AWREGION), .AWUSER_i(AWUSER), .AWQOS_i(AWQOS),
    .AWVALID_i(AWVALID), .AWREADY_o(AWREADY),
    .WDATA_i(WDATA), .WSTRB_i(WSTRB), .WLAST_i(WLAST), .WUSER_i(WUSER),
    .WVALID_i(WVALID), .WREADY_o(WREADY),
    .BID_o(BID), .BRESP_o(BRESP), .BUSER_o(BUSER), .BVALID_o(BVALID), .BREADY_i(BREADY),
    .MEM_CEN_o(MEM_CEN), .MEM_WEN_o(MEM_WEN), .MEM_A_o(MEM_A), .MEM_D_o(MEM_D),
    .MEM_BE_o(MEM_BE), .MEM_Q_i(MEM_Q),
    .valid_o(valid), .grant_i(grant)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  // Drives one AW handshake in IDLE and returns one cycle later.
  task automatic send_aw(input logic [15:0] id, input logic [31:0] addr,
                         input logic [7:0] len, input logic [1:0] burst);
    AWID = id; AWADDR = addr; AWLEN = len; AWBURST = burst;
    AWUSER = 10'h2A; AWVALID = 1'b1;
    step();
    AWVALID = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    WVALID = 1'b1; grant = 1'b1; WDATA = 64'hDEAD;
    repeat (2) step();
    @(negedge clk);
    checks++; if (AWREADY !== 1'b1) begin errors++; $display("FAIL reset_awready got %0b expected 1", AWREADY); end
    checks++; if (WREADY !== 1'b0)  begin errors++; $display("FAIL reset_wready got %0b expected 0", WREADY); end
    checks++; if (valid !== 1'b0)   begin errors++; $display("FAIL reset_valid got %0b expected 0", valid); end
    checks++; if ({MEM_CEN, MEM_WEN} !== 2'b11) begin errors++; $display("FAIL reset_mem_en got %0b expected 11", {MEM_CEN, MEM_WEN}); end
    checks++; if (BVALID !== 1'b0 || BID !== 16'h0 || BRESP !== RESP_OKAY || BUSER !== 10'h0) begin
      errors++; $display("FAIL reset_b got bvalid=%0b bid=%0h bresp=%0h buser=%0h expected 0 0 0 0", BVALID, BID, BRESP, BUSER);
    end
    step();
    rst = 1'b0;
    // W beat presented before any AW must not be taken.
    @(negedge clk);
    checks++; if (WREADY !== 1'b0 || MEM_WEN !== 1'b1) begin errors++; $display("FAIL early_w got wready=%0b wen=%0b expected 0 1", WREADY, MEM_WEN); end
    step();
    WVALID = 1'b0; grant = 1'b0;
  endtask

  task automatic test_single;
    send_aw(16'h5, 32'h40, 8'd0, BURST_INCR);
    WVALID = 1'b1; WDATA = 64'hA5A5; WSTRB = 8'hFF; WLAST = 1'b1; grant = 1'b1;
    @(negedge clk);
    checks++; if (MEM_A !== 13'd8) begin errors++; $display("FAIL single_addr got %0d expected 8", MEM_A); end
    checks++; if (MEM_WEN !== 1'b0 || MEM_CEN !== 1'b0 || WREADY !== 1'b1 || valid !== 1'b1) begin
      errors++; $display("FAIL single_beat got wen=%0b cen=%0b wready=%0b valid=%0b expected 0 0 1 1", MEM_WEN, MEM_CEN, WREADY, valid);
    end
    checks++; if (MEM_D !== 64'hA5A5 || MEM_BE !== 8'hFF) begin errors++; $display("FAIL single_data got %0h/%0h expected a5a5/ff", MEM_D, MEM_BE); end
    step();
    WVALID = 1'b0; WLAST = 1'b0;
    @(negedge clk);
    checks++; if (BVALID !== 1'b1 || BID !== 16'h5 || BRESP !== RESP_OKAY || BUSER !== 10'h2A) begin
      errors++; $display("FAIL single_b got bvalid=%0b bid=%0h bresp=%0h buser=%0h expected 1 5 0 2a", BVALID, BID, BRESP, BUSER);
    end
    checks++; if (MEM_WEN !== 1'b1) begin errors++; $display("FAIL single_wen_after got %0b expected 1", MEM_WEN); end
    BREADY = 1'b1;
    step();
    BREADY = 1'b0;
    @(negedge clk);
    checks++; if (BVALID !== 1'b0 || AWREADY !== 1'b1) begin errors++; $display("FAIL single_idle got bvalid=%0b awready=%0b expected 0 1", BVALID, AWREADY); end
  endtask

  task automatic test_incr;
    int k = 0;
    int cyc = 0;
    send_aw(16'h11, 32'd80, 8'd3, BURST_INCR);
    while (k < 4 && cyc < 20) begin
      grant = (cyc % 2 == 0); WVALID = 1'b1; WDATA = 64'h1000 + 64'(k); WSTRB = 8'hF0; WLAST = (k == 3);
      @(negedge clk);
      checks++; if (WREADY !== grant) begin errors++; $display("FAIL incr_wready cyc%0d got %0b expected %0b", cyc, WREADY, grant); end
      checks++; if (MEM_A !== 13'(10 + k)) begin errors++; $display("FAIL incr_addr cyc%0d got %0d expected %0d", cyc, MEM_A, 10 + k); end
      step();
      if (grant) k++;
      cyc++;
    end
    checks++; if (k != 4) begin errors++; $display("FAIL incr_beats got %0d expected 4", k); end
    WVALID = 1'b0; WLAST = 1'b0; grant = 1'b0;
    @(negedge clk);
    checks++; if (BVALID !== 1'b1 || BID !== 16'h11 || BRESP !== RESP_OKAY) begin
      errors++; $display("FAIL incr_b got bvalid=%0b bid=%0h bresp=%0h expected 1 11 0", BVALID, BID, BRESP);
    end
    BREADY = 1'b1; step(); BREADY = 1'b0;
  endtask

  task automatic test_fixed;
    send_aw(16'h22, 32'd56, 8'd2, BURST_FIXED);
    grant = 1'b1;
    for (int k = 0; k < 3; k++) begin
      WVALID = 1'b1; WDATA = 64'h7700 + 64'(k); WSTRB = 8'h0F; WLAST = (k == 2);
      @(negedge clk);
      checks++; if (MEM_A !== 13'd7 || MEM_WEN !== 1'b0) begin errors++; $display("FAIL fixed_addr beat%0d got %0d wen=%0b expected 7 0", k, MEM_A, MEM_WEN); end
      step();
    end
    WVALID = 1'b0; WLAST = 1'b0; grant = 1'b0;
    @(negedge clk);
    checks++; if (BVALID !== 1'b1 || BRESP !== RESP_OKAY) begin errors++; $display("FAIL fixed_b got bvalid=%0b bresp=%0h expected 1 0", BVALID, BRESP); end
    BREADY = 1'b1; step(); BREADY = 1'b0;
  endtask

  task automatic test_early_wlast;
    send_aw(16'h33, 32'd160, 8'd3, BURST_INCR);
    grant = 1'b1;
    for (int k = 0; k < 4; k++) begin
      WVALID = 1'b1; WDATA = 64'hBEEF0 + 64'(k); WSTRB = 8'hFF; WLAST = (k == 1);
      @(negedge clk);
      checks++; if (MEM_A !== 13'(20 + k) || MEM_WEN !== 1'b0 || BVALID !== 1'b0) begin
        errors++; $display("FAIL early_last beat%0d got addr=%0d wen=%0b bvalid=%0b expected %0d 0 0", k, MEM_A, MEM_WEN, BVALID, 20 + k);
      end
      step();
    end
    WVALID = 1'b0; WLAST = 1'b0; grant = 1'b0;
    @(negedge clk);
    checks++; if (BVALID !== 1'b1 || BRESP !== RESP_SLVERR) begin errors++; $display("FAIL early_last_b got bvalid=%0b bresp=%0h expected 1 2", BVALID, BRESP); end
    BREADY = 1'b1; step(); BREADY = 1'b0;
  endtask

  task automatic test_back_to_back;
    send_aw(16'h44, 32'd8, 8'd0, BURST_INCR);
    grant = 1'b1; WVALID = 1'b1; WLAST = 1'b1; WDATA = 64'h44;
    step();
    WVALID = 1'b0; WLAST = 1'b0;
    // Next AW waits while the response is stalled.
    AWID = 16'h55; AWADDR = 32'd24; AWLEN = 8'd0; AWBURST = BURST_INCR; AWVALID = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      checks++; if (BVALID !== 1'b1 || BID !== 16'h44 || AWREADY !== 1'b0) begin
        errors++; $display("FAIL bstall cyc%0d got bvalid=%0b bid=%0h awready=%0b expected 1 44 0", c, BVALID, BID, AWREADY);
      end
      step();
    end
    BREADY = 1'b1;
    @(negedge clk);
    checks++; if (AWREADY !== 1'b1 || BVALID !== 1'b1) begin errors++; $display("FAIL b2b_aw got awready=%0b bvalid=%0b expected 1 1", AWREADY, BVALID); end
    step();
    BREADY = 1'b0; AWVALID = 1'b0;
    WVALID = 1'b1; WLAST = 1'b1; WDATA = 64'h55;
    @(negedge clk);
    checks++; if (BVALID !== 1'b0 || WREADY !== 1'b1 || MEM_A !== 13'd3 || MEM_WEN !== 1'b0) begin
      errors++; $display("FAIL b2b_write got bvalid=%0b wready=%0b addr=%0d wen=%0b expected 0 1 3 0", BVALID, WREADY, MEM_A, MEM_WEN);
    end
    step();
    WVALID = 1'b0; WLAST = 1'b0;
    @(negedge clk);
    checks++; if (BVALID !== 1'b1 || BID !== 16'h55) begin errors++; $display("FAIL b2b_b got bvalid=%0b bid=%0h expected 1 55", BVALID, BID); end
    BREADY = 1'b1; step(); BREADY = 1'b0; grant = 1'b0;
  endtask

  task automatic test_wrap_reset;
    logic [12:0] exp_addr [4];
    exp_addr[0] = 13'd8190; exp_addr[1] = 13'd8191; exp_addr[2] = 13'd0; exp_addr[3] = 13'd1;
    send_aw(16'h66, 32'hFFF0, 8'd3, BURST_INCR);
    grant = 1'b1;
    for (int k = 0; k < 4; k++) begin
      WVALID = 1'b1; WDATA = 64'h6600 + 64'(k); WLAST = (k == 3);
      @(negedge clk);
      checks++; if (MEM_A !== exp_addr[k]) begin errors++; $display("FAIL wrap_addr beat%0d got %0d expected %0d", k, MEM_A, exp_addr[k]); end
      if (k < 3) step();
    end
    rst = 1'b1;
    #1;
    checks++; if (MEM_CEN !== 1'b1 || MEM_WEN !== 1'b1 || valid !== 1'b0 || WREADY !== 1'b0 || AWREADY !== 1'b1) begin
      errors++; $display("FAIL rst_mid got cen=%0b wen=%0b valid=%0b wready=%0b awready=%0b expected 1 1 0 0 1", MEM_CEN, MEM_WEN, valid, WREADY, AWREADY);
    end
    checks++; if (BVALID !== 1'b0 || BID !== 16'h0 || BRESP !== RESP_OKAY) begin
      errors++; $display("FAIL rst_mid_b got bvalid=%0b bid=%0h bresp=%0h expected 0 0 0", BVALID, BID, BRESP);
    end
    step();
    rst = 1'b0;
    repeat (3) step();
    @(negedge clk);
    checks++; if (BVALID !== 1'b0 || WREADY !== 1'b0) begin errors++; $display("FAIL rst_no_b got bvalid=%0b wready=%0b expected 0 0", BVALID, WREADY); end
    WVALID = 1'b0; WLAST = 1'b0; grant = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    AWID = '0; AWADDR = '0; AWLEN = '0; AWSIZE = 3'd3; AWBURST = BURST_INCR; AWLOCK = 1'b0;
    AWCACHE = '0; AWPROT = '0; AWREGION = '0; AWUSER = '0; AWQOS = '0; AWVALID = 1'b0;
    WDATA = '0; WSTRB = '0; WLAST = 1'b0; WUSER = '0; WVALID = 1'b0;
    BREADY = 1'b0; MEM_Q = '0; grant = 1'b0;

    test_reset();
    test_single();
    test_incr();
    test_fixed();
    test_early_wlast();
    test_back_to_back();
    test_wrap_reset();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
